// File: rtl/clk_div_mon_pkg.sv
// Shared types and default constants for the divided-clock monitor.
package clk_div_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_EXP_HALF = 3;
    localparam int DEF_LOCK_N   = 2;

endpackage

// File: rtl/clk_div_mon_if.sv
// Measurement handshake bundle: the monitor is master, the consumer is slave.
interface clk_div_mon_if #(
    parameter int CNT_W = 8
);
    logic             meas_valid;
    logic             meas_ready;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] low_cnt;
    logic             meas_err;

    modport master (
        output meas_valid, high_cnt, low_cnt, meas_err,
        input  meas_ready
    );

    modport slave (
        input  meas_valid, high_cnt, low_cnt, meas_err,
        output meas_ready
    );
endinterface

// File: rtl/clk_div_mon_edge.sv
// Edge detector for the divided clock; CLK_DIV_MON_SYNC_EN adds a two-flop
// synchronizer in front (2 cycles extra latency).
module clk_div_mon_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic div_in,
    output logic rise,
    output logic fall
);

    logic src;
    logic div_q;

`ifdef CLK_DIV_MON_SYNC_EN
    logic sync1;
    logic sync2;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= div_in;
            sync2 <= sync1;
        end
    end

    assign src = sync2;
`else
    assign src = div_in;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) div_q <= 1'b0;
        else          div_q <= src;
    end

    assign rise = src & ~div_q;
    assign fall = ~src & div_q;

endmodule

// File: rtl/clk_div_mon.sv
// Divided-clock period monitor: measures high/low durations, flags deviations,
// tracks lock. Optional input synchronizer via CLK_DIV_MON_SYNC_EN.
module clk_div_mon
    import clk_div_mon_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int EXP_HALF = DEF_EXP_HALF,
    parameter int LOCK_N   = DEF_LOCK_N
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           div_in,
    clk_div_mon_if.master  meas,
    output logic           overrun,
    output logic           stuck,
    output logic           lock
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] EXP       = CNT_W'(EXP_HALF);
    localparam int               LCK_W     = $clog2(LOCK_N + 1);
    localparam logic [LCK_W-1:0] LOCK_FULL = LCK_W'(LOCK_N);

    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] lcnt;
    logic [LCK_W-1:0] lock_cnt;
    logic             complete;
    logic             period_err;
    logic             accept;

    clk_div_mon_edge u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .div_in  (div_in),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = HIGH;
            HIGH:    if (fall) state_nxt = LOW;
            LOW:     if (rise) state_nxt = HIGH;
            default: state_nxt = IDLE;
        endcase
    end

    // Stuck drops lock combinationally so it clears in the same cycle it appears.
    always_comb begin
        complete   = (state == LOW) && rise;
        stuck      = ((state == HIGH) && (hcnt == CNT_MAX)) ||
                     ((state == LOW)  && (lcnt == CNT_MAX));
        period_err = (hcnt != EXP) || (lcnt != EXP) ||
                     (hcnt == CNT_MAX) || (lcnt == CNT_MAX);
        accept     = !meas.meas_valid || meas.meas_ready;
        lock       = (lock_cnt == LOCK_FULL) && !stuck;
    end

    // Edge cycles load 1; the fall cycle must not bump the high count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hcnt <= '0;
            lcnt <= '0;
        end else begin
            if (rise)
                hcnt <= CNT_W'(1);
            else if ((state == HIGH) && !fall && (hcnt != CNT_MAX))
                hcnt <= hcnt + CNT_W'(1);

            if (fall && (state == HIGH))
                lcnt <= CNT_W'(1);
            else if ((state == LOW) && !rise && (lcnt != CNT_MAX))
                lcnt <= lcnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meas.meas_valid <= 1'b0;
            meas.high_cnt   <= '0;
            meas.low_cnt    <= '0;
            meas.meas_err   <= 1'b0;
            overrun         <= 1'b0;
        end else if (complete) begin
            if (accept) begin
                meas.meas_valid <= 1'b1;
                meas.high_cnt   <= hcnt;
                meas.low_cnt    <= lcnt;
                meas.meas_err   <= period_err;
            end else begin
                overrun <= 1'b1;
            end
        end else if (meas.meas_valid && meas.meas_ready) begin
            meas.meas_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            lock_cnt <= '0;
        else if (stuck)
            lock_cnt <= '0;
        else if (complete) begin
            if (period_err)
                lock_cnt <= '0;
            else if (lock_cnt != LOCK_FULL)
                lock_cnt <= lock_cnt + LCK_W'(1);
        end
    end

endmodule

// File: tb/tb_clk_div_mon.sv
// Directed bench for clk_div_mon; also valid when built with CLK_DIV_MON_SYNC_EN.
module tb_clk_div_mon;
    import clk_div_mon_pkg::*;

`ifdef CLK_DIV_MON_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic [7:0] h;
        logic [7:0] l;
        logic       e;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic div_in = 1'b0;
    logic overrun, stuck, lock;
    logic overrun4, stuck4, lock4;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    clk_div_mon_if #(.CNT_W(8)) mif ();
    clk_div_mon_if #(.CNT_W(4)) mif4 ();

    clk_div_mon #(.CNT_W(8), .EXP_HALF(3), .LOCK_N(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .div_in  (div_in),
        .meas    (mif.master),
        .overrun (overrun),
        .stuck   (stuck),
        .lock    (lock)
    );

    clk_div_mon #(.CNT_W(4), .EXP_HALF(3), .LOCK_N(2)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .div_in  (div_in),
        .meas    (mif4.master),
        .overrun (overrun4),
        .stuck   (stuck4),
        .lock    (lock4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input int h, input int l);
        exp_t x;
        x.h = 8'(h);
        x.l = 8'(l);
        x.e = (h != 3) || (l != 3) || (h >= 255) || (l >= 255);
        exp_q.push_back(x);
    endtask

    task automatic drive(input logic lvl, input int n);
        if (n == 0) return;
        div_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        div_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"},   mif.meas_valid, 0);
        chk({tag, "_high"},    mif.high_cnt, 0);
        chk({tag, "_low"},     mif.low_cnt, 0);
        chk({tag, "_err"},     mif.meas_err, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_stuck"},   stuck, 0);
        chk({tag, "_lock"},    lock, 0);
    endtask

    // Scoreboard: every accepted handshake consumes the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && mif.meas_valid && mif.meas_ready) begin
            chk("expect_available", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_high_cnt", mif.high_cnt, e.h);
                chk("sb_low_cnt",  mif.low_cnt,  e.l);
                chk("sb_meas_err", mif.meas_err, e.e);
            end
        end
    end

    initial begin
        mif.meas_ready  = 1'b1;
        mif4.meas_ready = 1'b1;

        // Divide-by-6 source: latency, counts and lock
        do_reset();
        chk_zero("reset");
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        push_exp(3, 3);
        div_in = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("latency_before", mif.meas_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_at", mif.meas_valid, 1);
        chk("lock_after_p1", lock, 0);
        drive(1, 3 - LAT);
        drive(0, 3);
        push_exp(3, 3);
        div_in = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        chk("lock_after_p2", lock, 1);
        drive(1, 3 - LAT);
        drive(0, 3);
        drive(1, 3);
        drive(0, 2);
        chk("s1_queue_empty", exp_q.size(), 0);

        // 4 high / 2 low: wrong duty cycle never locks
        do_reset();
        push_exp(4, 2);
        drive(1, 4);
        drive(0, 2);
        push_exp(4, 2);
        drive(1, 4);
        drive(0, 2);
        drive(1, 4);
        chk("lock_bad_duty", lock, 0);
        drive(0, 2);
        chk("s2_queue_empty", exp_q.size(), 0);

        // Stalled consumer: first result held, later ones dropped
        do_reset();
        mif.meas_ready = 1'b0;
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        drive(1, 4);
        drive(0, 2);
        drive(1, 2);
        drive(0, 4);
        drive(1, LAT);
        chk("held_valid",   mif.meas_valid, 1);
        chk("held_high",    mif.high_cnt, 3);
        chk("held_low",     mif.low_cnt, 3);
        chk("held_err",     mif.meas_err, 0);
        chk("overrun_set",  overrun, 1);
        mif.meas_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("valid_cleared",  mif.meas_valid, 0);
        chk("overrun_sticky", overrun, 1);
        chk("s3_queue_empty", exp_q.size(), 0);

        // Lock, then a 20-cycle high phase saturates the 4-bit counter
        do_reset();
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        push_exp(20, 3);
        div_in = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        chk("lock4_before_stuck", lock4, 1);
        chk("lock8_before_stuck", lock, 1);
        repeat (13) @(posedge clk);
        #1;
        chk("stuck4_at_14", stuck4, 0);
        chk("lock4_at_14",  lock4, 1);
        @(posedge clk);
        #1;
        chk("stuck4_at_15", stuck4, 1);
        chk("lock4_at_15",  lock4, 0);
        repeat (6 - LAT) @(posedge clk);
        #1;
        chk("stuck4_at_20", stuck4, 1);
        chk("stuck8_at_20", stuck, 0);
        drive(0, 3);
        drive(1, LAT);
        chk("sat_valid4", mif4.meas_valid, 1);
        chk("sat_high4",  mif4.high_cnt, 15);
        chk("sat_low4",   mif4.low_cnt, 3);
        chk("sat_err4",   mif4.meas_err, 1);
        chk("sat_lock4",  lock4, 0);
        drive(1, 2);
        drive(0, 2);
        chk("s4_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a HIGH phase
        do_reset();
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        drive(1, LAT + 1);
        reset_n = 1'b0;
        div_in  = 1'b0;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        reset_n = 1'b1;
        drive(0, 2);
        chk("post_release_valid", mif.meas_valid, 0);
        push_exp(3, 3);
        drive(1, 3);
        drive(0, 3);
        drive(1, 3);
        drive(0, 2);
        chk("s5_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_div_mon.md
CLK_DIV_MON -- requirements
Module: clk_div_mon

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the high/low duration counters.
REQ-002 SHALL have parameter EXP_HALF, default 3: expected half-period in clk cycles (matches a divide-by-6 source).
REQ-003 SHALL have parameter LOCK_N, default 2: number of consecutive error-free periods before lock.
REQ-004 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port div_in  input  1  divided-clock level, synchronous to clk.
REQ-007 SHALL have port meas_valid  output  1  measurement available.
REQ-008 SHALL have port meas_ready  input  1  consumer accepts the measurement.
REQ-009 SHALL have port high_cnt  output  CNT_W  clk cycles that div_in was sampled high.
REQ-010 SHALL have port low_cnt  output  CNT_W  clk cycles that div_in was sampled low.
REQ-011 SHALL have port meas_err  output  1  period deviates from EXP_HALF/EXP_HALF, or a count saturated.
REQ-012 SHALL have port overrun  output  1  sticky: a measurement was dropped while output stalled.
REQ-013 SHALL have port stuck  output  1  active counter saturated (no edge for 2^CNT_W-1 cycles).
REQ-014 SHALL have port lock  output  1  LOCK_N consecutive good periods seen.

Function
REQ-015 SHALL register div_in into div_q; rise = div_in & ~div_q, fall = ~div_in & div_q.
REQ-016 SHALL implement FSM states IDLE, HIGH, LOW; IDLE->HIGH on rise (partial first period discarded), HIGH->LOW on fall, LOW->HIGH on rise.
REQ-017 SHALL load hcnt=1 on the rise cycle and increment each HIGH cycle; load lcnt=1 on the fall cycle and increment each LOW cycle.
REQ-018 SHALL saturate hcnt/lcnt at 2^CNT_W-1 (no wrap) and assert stuck while the active counter is saturated.
REQ-019 SHALL complete a period on the LOW->HIGH rise; the result appears on outputs the next cycle (latency 1 from rise).
REQ-020 SHALL load high_cnt/low_cnt/meas_err and set meas_valid when meas_valid=0 or (meas_valid & meas_ready) in the completing cycle.
REQ-021 SHALL hold outputs stable while meas_valid=1 and meas_ready=0; a period completing then is dropped and sets overrun.
REQ-022 SHALL clear meas_valid the cycle after meas_valid & meas_ready with no new result.
REQ-023 SHALL compute meas_err = (high!=EXP_HALF) | (low!=EXP_HALF) | either count saturated.
REQ-024 SHALL count consecutive error-free completed periods (saturating at LOCK_N); lock=1 when count==LOCK_N; an error period or stuck clears the count and lock in the same cycle.
REQ-025 SHALL evaluate lock on every completed period, including dropped ones.

Reset
REQ-026 SHALL, on reset_n=0 at posedge clk, set state=IDLE, div_q=0, hcnt=lcnt=0, meas_valid=0, high_cnt=low_cnt=0, meas_err=0, overrun=0, stuck=0, lock=0, lock count=0.
REQ-027 SHALL abort any period in progress on mid-operation reset; the first period after release is discarded per REQ-016.

Configuration
REQ-028 SHALL, with CLK_DIV_MON_SYNC_EN defined, pass div_in through a two-flop synchronizer (reset 0) before edge detection, adding 2 cycles latency.
REQ-029 SHALL, without CLK_DIV_MON_SYNC_EN, use div_in directly; all other behaviour is identical.

Structure
REQ-030 SHALL place the FSM state enum (IDLE, HIGH, LOW) and default constants in shared package clk_div_mon_pkg.
REQ-031 SHALL implement edge detection plus optional synchronizer as sub-module clk_div_mon_edge (outputs rise, fall).

Verification
REQ-032 SHALL test: div_in driven by a divide-by-6 source, meas_ready=1 -> first result high_cnt=3, low_cnt=3, meas_err=0; lock=1 after the 2nd completed period.
REQ-033 SHALL test: 4 cycles high / 2 low -> high_cnt=4, low_cnt=2, meas_err=1, lock=0.
REQ-034 SHALL test: meas_ready=0 over 3 periods -> first result held stable, overrun=1; meas_ready=1 -> one handshake, then meas_valid=0.
REQ-035 SHALL test: CNT_W=4, div_in held high 20 cycles -> stuck=1 at 15 cycles, lock=0; next period reports high_cnt=15, meas_err=1.
REQ-036 SHALL test: reset_n=0 during HIGH -> all outputs 0 next cycle; first period after release discarded.
REQ-037 SHALL test: with CLK_DIV_MON_SYNC_EN, REQ-032 stimulus -> identical counts, meas_valid 2 cycles later.
